// File: rtl/cla_pkg.sv
// Shared definitions for the sliced carry-lookahead add/subtract unit.
// Latency: n/a (types, constants and a sizing helper only).
// Backpressure: n/a.
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice counter width; a single-slice build still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;
   localparam int N_CHUNKS  = DEF_WIDTH / DEF_CHUNK;
   localparam int CNT_W     = cnt_width(N_CHUNKS);

endpackage

// File: rtl/cla_group.sv
// Flat two-level carry-lookahead group over W bits.
// Latency: purely combinational.
// Backpressure: none (no state).
module cla_group #(
   parameter int W = 8
) (
   input  logic [W-1:0] p,
   input  logic [W-1:0] g,
   input  logic         cin,
   output logic [W-1:0] carry,
   output logic         cout
);

   logic [W:0] c;
   logic       term;

   // Each c[i+1] is an OR of product terms: cin propagated through p[0..i],
   // plus every g[j] propagated through p[j+1..i]. No ripple between bits.
   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         term = cin;
         for (int k = 0; k <= i; k++) term = term & p[k];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign carry = c[W-1:0];
   assign cout  = c[W];

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit lookahead slice per clock; flags carry, signed overflow, zero.
// Latency: N=WIDTH/CHUNK RUN cycles, out_valid rises on the edge that ends the last slice; back-to-back issue from DONE.
// Backpressure: result and flags hold while out_ready is low; in_ready only in IDLE or DONE&out_ready. Macro CLA_SAT_EN saturates on overflow.
module cla_addsub_seq
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_width(N);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r, res_r;
   logic             carry_r;
   logic             accept, last;

   logic [CHUNK-1:0] p_k, g_k, c_k, slice;
   logic             c_out;
   int               base;
   logic [WIDTH-1:0] res_nxt, fin;
   logic             msb_cin, ovf_nxt;

   assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign last     = (cnt == CW'(N - 1));

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN:  if (last) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = accept ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Current slice: generate/propagate and its lookahead result.
   always_comb begin
      base  = int'(cnt) * CHUNK;
      p_k   = a_r[base +: CHUNK] ^ b_r[base +: CHUNK];
      g_k   = a_r[base +: CHUNK] & b_r[base +: CHUNK];
   end

   cla_group #(.W(CHUNK)) u_group (
      .p     (p_k),
      .g     (g_k),
      .cin   (carry_r),
      .carry (c_k),
      .cout  (c_out)
   );

   // Merge the slice into the partial result and form the final value on the last slice.
   always_comb begin
      slice   = p_k ^ c_k;
      res_nxt = res_r;
      res_nxt[base +: CHUNK] = slice;
      msb_cin = c_k[CHUNK-1];
      ovf_nxt = c_out ^ msb_cin;
`ifdef CLA_SAT_EN
      if (ovf_nxt) fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else         fin = res_nxt;
`else
      fin = res_nxt;
`endif
   end

   // Operand capture, per-slice carry chain and result/flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         carry_r <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= b ^ {WIDTH{sub}};
         carry_r <= sub;
         cnt     <= '0;
      end else if (state == RUN) begin
         carry_r <= c_out;
         res_r   <= res_nxt;
         cnt     <= cnt + CW'(1);
         if (last) begin
            sum  <= fin;
            cout <= c_out;
            ovf  <= ovf_nxt;
            zero <= (fin == '0);
         end
      end
   end

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Directed bench for cla_addsub_seq: a 32/8 instance and a single-slice 16/16 instance.
// Latency is counted with the accept edge as edge 1.
// Backpressure is exercised by stalling out_ready in DONE and re-issuing on release.
module tb_cla_addsub_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b0;
   logic [31:0] a = '0, b = '0, sum;
   logic        cout, ovf, zero;

   logic        in_valid2 = 1'b0, in_ready2, sub2 = 1'b0, out_valid2, out_ready2 = 1'b0;
   logic [15:0] a2 = '0, b2 = '0, sum2;
   logic        cout2, ovf2, zero2;

   int nchk = 0;
   int nerr = 0;

`ifdef CLA_SAT_EN
   localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] OVF_NEG = 32'h8000_0000;
   localparam logic [15:0] OVF_POS16 = 16'h7FFF;
`else
   localparam logic [31:0] OVF_POS = 32'h8000_0000;
   localparam logic [31:0] OVF_NEG = 32'h7FFF_FFFF;
   localparam logic [15:0] OVF_POS16 = 16'h8000;
`endif

   always #5 clk = ~clk;

   cla_addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   cla_addsub_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present operands at a falling edge, let the next rising edge accept them, then scramble the inputs.
   task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
      @(negedge clk);
      a = ta; b = tb_; sub = ts; in_valid = 1'b1;
      chk("in_ready before accept", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~ta; b = ~tb_; sub = ~ts;
   endtask

   // Called #1 after the accept edge; expects out_valid after edge 5 (accept edge = 1).
   task automatic wait_out(input string tag);
      int e;
      e = 1;
      while (!out_valid && e < 40) begin
         @(posedge clk); #1;
         e++;
      end
      chk({tag, " latency"}, e, 32'd5);
   endtask

   task automatic expect_res(input string tag, input logic [31:0] es, input logic ec, input logic eo, input logic ez);
      chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, " sum"}, sum, es);
      chk({tag, " cout"}, {31'b0, cout}, {31'b0, ec});
      chk({tag, " ovf"}, {31'b0, ovf}, {31'b0, eo});
      chk({tag, " zero"}, {31'b0, zero}, {31'b0, ez});
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " out_valid after drain"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int seen;
      int e;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst sum", sum, 32'd0);
      chk("rst flags", {29'b0, cout, ovf, zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle in_ready", {31'b0, in_ready}, 32'd1);

      // Carry out of all four slices, wraps to zero.
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_out("ffff+1");
      expect_res("ffff+1", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      drain("ffff+1");

      // Subtract with borrow, then without.
      issue(32'd5, 32'd7, 1'b1);
      wait_out("5-7");
      expect_res("5-7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      drain("5-7");

      issue(32'd7, 32'd5, 1'b1);
      wait_out("7-5");
      expect_res("7-5", 32'd2, 1'b1, 1'b0, 1'b0);
      drain("7-5");

      // Signed overflow both directions.
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_out("maxpos+1");
      expect_res("maxpos+1", OVF_POS, 1'b0, 1'b1, 1'b0);
      drain("maxpos+1");

      issue(32'h8000_0000, 32'h0000_0001, 1'b1);
      wait_out("minneg-1");
      expect_res("minneg-1", OVF_NEG, 1'b1, 1'b1, 1'b0);
      drain("minneg-1");

      // 0-0: no borrow, zero result.
      issue(32'd0, 32'd0, 1'b1);
      wait_out("0-0");
      expect_res("0-0", 32'd0, 1'b1, 1'b0, 1'b1);
      drain("0-0");

      // Mixed carries across slice boundaries, then backpressure in DONE.
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      wait_out("mix");
      expect_res("mix", 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; a = 32'hFFFF_0000; b = 32'h1111_1111; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall out_valid", {31'b0, out_valid}, 32'd1);
         chk("stall sum", sum, 32'hACF1_3568);
         chk("stall flags", {29'b0, cout, ovf, zero}, 32'd0);
         chk("stall in_ready", {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      a = 32'd7; b = 32'd5; sub = 1'b1; out_ready = 1'b1;
      #1;
      chk("release in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
      chk("b2b out_valid drop", {31'b0, out_valid}, 32'd0);
      chk("b2b sum held", sum, 32'hACF1_3568);
      wait_out("b2b");
      expect_res("b2b", 32'd2, 1'b1, 1'b0, 1'b0);
      drain("b2b");

      // Reset during the second RUN cycle aborts the operation.
      issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid-rst in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("mid-rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid-rst sum", sum, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("aborted op never valid", seen, 32'd0);
      chk("mid-rst idle in_ready", {31'b0, in_ready}, 32'd1);

      // Single-slice instance: 16-bit add in one RUN cycle.
      @(negedge clk);
      a2 = 16'h1234; b2 = 16'h4321; sub2 = 1'b0; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0; a2 = '0; b2 = '0;
      e = 1;
      while (!out_valid2 && e < 20) begin
         @(posedge clk); #1;
         e++;
      end
      chk("n1 latency", e, 32'd2);
      chk("n1 sum", {16'b0, sum2}, 32'h0000_5555);
      chk("n1 flags", {29'b0, cout2, ovf2, zero2}, 32'd0);
      @(negedge clk);
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      chk("n1 drain", {31'b0, out_valid2}, 32'd0);

      // Single-slice overflow: sign carry comes from inside the group.
      @(negedge clk);
      a2 = 16'h7FFF; b2 = 16'h0001; sub2 = 1'b0; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      e = 1;
      while (!out_valid2 && e < 20) begin
         @(posedge clk); #1;
         e++;
      end
      chk("n1 ovf latency", e, 32'd2);
      chk("n1 ovf sum", {16'b0, sum2}, {16'b0, OVF_POS16});
      chk("n1 ovf flags", {29'b0, cout2, ovf2, zero2}, 32'b010);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
